// File: rtl/alu_op_sequencer_if.sv
// Request/response channels between the decode stage and alu_op_sequencer.
// The slave modport is the sequencer's view; the master modport is the decode/consumer view.
`timescale 1ns/1ps
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              reqValid;
  logic              reqReady;
  logic [5:0]        reqOp;
  logic [5:0]        reqFunct;
  logic [DATA_W-1:0] reqA;
  logic [DATA_W-1:0] reqB;
  logic              respValid;
  logic              respReady;
  logic [DATA_W-1:0] respResult;
  logic              respZero;
  logic              respErr;
  logic              respTaken;

  modport master (
    output reqValid, reqOp, reqFunct, reqA, reqB, respReady,
    input  reqReady, respValid, respResult, respZero, respErr, respTaken
  );

  modport slave (
    input  reqValid, reqOp, reqFunct, reqA, reqB, respReady,
    output reqReady, respValid, respResult, respZero, respErr, respTaken
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue-side driver for a combinational 32-bit ALU: decodes opcode/funct to ALUctrl,
// holds ALU inputs STALL_CYCLES cycles, captures the result. Optional macro: ALU_BRANCH_EN.
`timescale 1ns/1ps
module alu_op_sequencer #(
  parameter int DATA_W       = 32,
  parameter int STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [DATA_W-1:0] ALUin1,
  output logic [DATA_W-1:0] ALUin2,
  output logic [3:0]        ALUctrl,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic              ALUzero
);
  localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;
  logic              taken_q, taken_d;
  logic [1:0]        br_q, br_d;          // bit0 = beq, bit1 = bne

  logic [3:0]        dec_ctrl;
  logic              dec_legal;
  logic [1:0]        dec_br;

  always_comb begin
    dec_ctrl  = 4'b0000;
    dec_legal = 1'b0;
    dec_br    = 2'b00;
    case (bus.reqOp)
      6'h00: begin
        case (bus.reqFunct)
          6'h24: begin dec_ctrl = 4'b0000; dec_legal = 1'b1; end
          6'h25: begin dec_ctrl = 4'b0001; dec_legal = 1'b1; end
          6'h20: begin dec_ctrl = 4'b0010; dec_legal = 1'b1; end
          6'h22: begin dec_ctrl = 4'b0110; dec_legal = 1'b1; end
          6'h2A: begin dec_ctrl = 4'b0111; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      6'h08: begin dec_ctrl = 4'b0010; dec_legal = 1'b1; end
      6'h0C: begin dec_ctrl = 4'b0000; dec_legal = 1'b1; end
      6'h0D: begin dec_ctrl = 4'b0001; dec_legal = 1'b1; end
      6'h0A: begin dec_ctrl = 4'b0111; dec_legal = 1'b1; end
      6'h23: begin dec_ctrl = 4'b0010; dec_legal = 1'b1; end
      6'h2B: begin dec_ctrl = 4'b0010; dec_legal = 1'b1; end
`ifdef ALU_BRANCH_EN
      6'h04: begin dec_ctrl = 4'b0110; dec_legal = 1'b1; dec_br = 2'b01; end
      6'h05: begin dec_ctrl = 4'b0110; dec_legal = 1'b1; dec_br = 2'b10; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_in1_d = alu_in1_q;
    alu_in2_d = alu_in2_q;
    alu_ctrl_d = alu_ctrl_q;
    result_d  = result_q;
    zero_d    = zero_q;
    err_d     = err_q;
    taken_d   = taken_q;
    br_d      = br_q;
    case (state_q)
      S_IDLE: begin
        if (bus.reqValid && req_ready_q) begin
          if (dec_legal) begin
            alu_in1_d  = bus.reqA;
            alu_in2_d  = bus.reqB;
            alu_ctrl_d = dec_ctrl;
            br_d       = dec_br;
            cnt_d      = STALL_INIT;
            state_d    = S_DRIVE;
          end else begin
            // Illegal requests leave the ALU inputs untouched and answer immediately
            result_d = '0;
            zero_d   = 1'b0;
            err_d    = 1'b1;
            taken_d  = 1'b0;
            state_d  = S_RESP;
          end
        end
      end
      S_DRIVE: begin
        if (cnt_q == 4'd0) begin
          result_d = ALUresult;
          zero_d   = ALUzero;
          err_d    = 1'b0;
`ifdef ALU_BRANCH_EN
          taken_d  = (br_q[0] & ALUzero) | (br_q[1] & ~ALUzero);
`else
          taken_d  = 1'b0;
`endif
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.respReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Ready follows the state being entered, so it is low for the whole op
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_ctrl_q  <= 4'd0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      taken_q     <= 1'b0;
      br_q        <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_ctrl_q  <= alu_ctrl_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      taken_q     <= taken_d;
      br_q        <= br_d;
    end
  end

  assign bus.reqReady   = req_ready_q;
  assign bus.respValid  = (state_q == S_RESP);
  assign bus.respResult = result_q;
  assign bus.respZero   = zero_q;
  assign bus.respErr    = err_q;
  assign bus.respTaken  = taken_q;
  assign ALUin1         = alu_in1_q;
  assign ALUin2         = alu_in2_q;
  assign ALUctrl        = alu_ctrl_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: STALL_CYCLES=1 instance for decode/handshake,
// STALL_CYCLES=4 instance for stall timing and reset-in-DRIVE.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(32)) bus ();
  alu_op_sequencer_if #(.DATA_W(32)) bus4 ();

  logic [31:0] in1, in2, res, in1_4, in2_4, res_4;
  logic [3:0]  ctrl, ctrl_4;
  logic        zero, zero_4;

  alu_op_sequencer #(.DATA_W(32), .STALL_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .ALUin1(in1), .ALUin2(in2), .ALUctrl(ctrl),
    .ALUresult(res), .ALUzero(zero)
  );

  alu_op_sequencer #(.DATA_W(32), .STALL_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
    .ALUin1(in1_4), .ALUin2(in2_4), .ALUctrl(ctrl_4),
    .ALUresult(res_4), .ALUzero(zero_4)
  );

  // Behavioural stand-in for the combinational ALU
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign res    = alu_f(ctrl, in1, in2);
  assign zero   = (in1 == in2);
  assign res_4  = alu_f(ctrl_4, in1_4, in2_4);
  assign zero_4 = (in1_4 == in2_4);

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
    logic        taken;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int npushed = 0;
  int nresp = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  // Monitor: one comparison per response handshake
  always @(negedge clk) begin
    if (rst_n && bus.respValid && bus.respReady) begin
      checks++;
      nresp++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got res=%h z=%b e=%b t=%b exp none",
                 bus.respResult, bus.respZero, bus.respErr, bus.respTaken);
      end else begin
        mon_e = sbq.pop_front();
        if ({bus.respResult, bus.respZero, bus.respErr, bus.respTaken} !== mon_e) begin
          errors++;
          $display("FAIL resp%0d got res=%h z=%b e=%b t=%b exp res=%h z=%b e=%b t=%b", nresp,
                   bus.respResult, bus.respZero, bus.respErr, bus.respTaken,
                   mon_e.result, mon_e.zero, mon_e.err, mon_e.taken);
        end else begin
          $display("resp%0d res=%h z=%b e=%b t=%b", nresp,
                   bus.respResult, bus.respZero, bus.respErr, bus.respTaken);
        end
      end
    end
  end

  // Called at #1 after a posedge; returns at #1 after the accept edge
  task automatic issue(input logic [5:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    int n = 0;
    bus.reqOp = op; bus.reqFunct = f; bus.reqA = a; bus.reqB = b;
    bus.reqValid = 1'b1;
    while (!bus.reqReady && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL req_timeout got reqReady=0 exp 1 op=%h", op);
    end
    sbq.push_back(e);
    npushed++;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
  endtask

  task automatic issue4(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus4.reqOp = 6'h00; bus4.reqFunct = f; bus4.reqA = a; bus4.reqB = b;
    bus4.reqValid = 1'b1;
    while (!bus4.reqReady && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL req4_timeout got reqReady=0 exp 1");
    end
    @(posedge clk); #1;
    bus4.reqValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e_beq, e_bne;
    int n;
    bus.reqValid = 0; bus.reqOp = 0; bus.reqFunct = 0; bus.reqA = 0; bus.reqB = 0;
    bus.respReady = 1;
    bus4.reqValid = 0; bus4.reqOp = 0; bus4.reqFunct = 0; bus4.reqA = 0; bus4.reqB = 0;
    bus4.respReady = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reqReady", bus.reqReady, 0);
    chk("rst_respValid", bus.respValid, 0);
    chk("rst_respResult", bus.respResult, 0);
    chk("rst_ALUin1", in1, 0);
    chk("rst_ALUctrl", ctrl, 0);
    chk("rst_respErr", bus.respErr, 0);
    chk("rst_respTaken", bus.respTaken, 0);
    rst_n = 1'b1;
    chk("reqReady_before_edge", bus.reqReady, 0);
    @(posedge clk); #1;
    chk("reqReady_after_edge", bus.reqReady, 1);

    // ADD with timing
    issue(6'h00, 6'h20, 32'd5, 32'd7, '{32'd12, 1'b0, 1'b0, 1'b0});
    chk("add_ALUctrl", ctrl, 4'b0010);
    chk("add_ALUin1", in1, 5);
    chk("add_ALUin2", in2, 7);
    chk("add_respValid_T1", bus.respValid, 0);
    chk("add_reqReady_T1", bus.reqReady, 0);
    @(posedge clk); #1;
    chk("add_respValid_T2", bus.respValid, 1);
    @(posedge clk); #1;
    chk("add_respValid_after_hs", bus.respValid, 0);
    chk("add_reqReady_after_hs", bus.reqReady, 1);

    // SUB equal, slti
    issue(6'h00, 6'h22, 32'h1234, 32'h1234, '{32'd0, 1'b1, 1'b0, 1'b0});
    issue(6'h0A, 6'h00, 32'd3, 32'd9, '{32'd1, 1'b0, 1'b0, 1'b0});
    chk("slti_ALUctrl", ctrl, 4'b0111);

    // Illegal opcode: immediate response, ALU inputs unchanged
    issue(6'h3F, 6'h00, 32'hAAAA, 32'hBBBB, '{32'd0, 1'b0, 1'b1, 1'b0});
    chk("ill_respValid_T1", bus.respValid, 1);
    chk("ill_ALUin1_kept", in1, 3);
    chk("ill_ALUin2_kept", in2, 9);
    chk("ill_ALUctrl_kept", ctrl, 4'b0111);
    issue(6'h00, 6'h3F, 32'h1, 32'h2, '{32'd0, 1'b0, 1'b1, 1'b0});

    // Remaining decodes
    issue(6'h00, 6'h24, 32'h0000F0F0, 32'h0000FF00, '{32'h0000F000, 1'b0, 1'b0, 1'b0});
    issue(6'h00, 6'h25, 32'h0000F0F0, 32'h0000FF00, '{32'h0000FFF0, 1'b0, 1'b0, 1'b0});
    issue(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, '{32'd1, 1'b0, 1'b0, 1'b0});
    issue(6'h08, 6'h00, 32'd100, 32'hFFFFFFFF, '{32'd99, 1'b0, 1'b0, 1'b0});
    issue(6'h0C, 6'h00, 32'hFF, 32'h0F, '{32'h0F, 1'b0, 1'b0, 1'b0});
    issue(6'h0D, 6'h00, 32'hF0, 32'h0F, '{32'hFF, 1'b0, 1'b0, 1'b0});
    issue(6'h23, 6'h00, 32'h1000, 32'd4, '{32'h1004, 1'b0, 1'b0, 1'b0});
    issue(6'h2B, 6'h00, 32'h2000, 32'd8, '{32'h2008, 1'b0, 1'b0, 1'b0});

    // Branches
`ifdef ALU_BRANCH_EN
    e_beq = '{32'd0, 1'b1, 1'b0, 1'b1};
    e_bne = '{32'd0, 1'b1, 1'b0, 1'b0};
`else
    e_beq = '{32'd0, 1'b0, 1'b1, 1'b0};
    e_bne = '{32'd0, 1'b0, 1'b1, 1'b0};
`endif
    issue(6'h04, 6'h00, 32'd4, 32'd4, e_beq);
    issue(6'h05, 6'h00, 32'd4, 32'd4, e_bne);

    // Backpressure
    @(posedge clk); #1;
    bus.respReady = 1'b0;
    issue(6'h00, 6'h20, 32'd10, 32'd20, '{32'd30, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("bp_respValid", bus.respValid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_respValid", bus.respValid, 1);
      chk("bp_hold_reqReady", bus.reqReady, 0);
      chk("bp_hold_respResult", bus.respResult, 30);
    end
    bus.respReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_respValid_after_hs", bus.respValid, 0);
    chk("bp_reqReady_after_hs", bus.reqReady, 1);

    // STALL_CYCLES=4: respValid visible after edge T+4 (sampled at T+5)
    issue4(6'h22, 32'd9, 32'd4);
    chk("st4_respValid_T", bus4.respValid, 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("st4_respValid_wait", bus4.respValid, 0);
    end
    @(posedge clk); #1;
    chk("st4_respValid_T4", bus4.respValid, 1);
    chk("st4_respResult", bus4.respResult, 5);
    chk("st4_respErr", bus4.respErr, 0);
    bus4.respReady = 1'b1;
    @(posedge clk); #1;
    chk("st4_respValid_after_hs", bus4.respValid, 0);
    chk("st4_reqReady_after_hs", bus4.reqReady, 1);

    // Reset while in DRIVE
    issue4(6'h20, 32'd1, 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstd_ALUin1", in1_4, 0);
    chk("rstd_ALUctrl", ctrl_4, 0);
    chk("rstd_reqReady", bus4.reqReady, 0);
    chk("rstd_respValid", bus4.respValid, 0);
    chk("rstd_dut1_reqReady", bus.reqReady, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rstd_reqReady_before_edge", bus4.reqReady, 0);
    @(posedge clk); #1;
    chk("rstd_reqReady_after_edge", bus4.reqReady, 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("rstd_no_resp", bus4.respValid, 0);
    end

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    chk("resp_count", nresp, npushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
